// File: rtl/wr_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wr_disp_pkg
// Description : Shared definitions for the AXI write-beat dispatcher:
//               region encodings, dispatcher state type and the default
//               FIFO backpressure timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package wr_disp_pkg;

    // Target region carried with every write beat
    localparam logic [1:0] REG_FIFO = 2'd0;
    localparam logic [1:0] REG_IRAM = 2'd1;
    localparam logic [1:0] REG_WRAM = 2'd2;
    localparam logic [1:0] REG_RSVD = 2'd3;

    // Dispatcher sequencing states
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RAM_WR    = 2'd1,
        S_FIFO_WAIT = 2'd2,
        S_RESP      = 2'd3
    } disp_state_t;

    // Default number of cycles to tolerate fifo_full before erroring
    localparam int FIFO_TO_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/wr_ram_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module      : wr_ram_dispatch_if
// Description : Bundle of every signal around the write-beat dispatcher:
//               upstream beat inputs, IRAM/WRAM BRAM ports, input FIFO port,
//               completion/error pulses and the completed-beat counter.
//               slave  : dispatcher view
//               master : environment view (upstream, BRAMs, FIFO)
// Revision    : 1.0 - initial release
// ============================================================================
interface wr_ram_dispatch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int RAM_AW = 9
);
    // Upstream write beat
    logic                  axi_wr_vld;
    logic [ADDR_W-1:0]     axi_wr_addr;
    logic [DATA_W-1:0]     axi_wr_data;
    logic [DATA_W/8-1:0]   axi_wr_strb;
    logic [1:0]            axi_wr_region;
    // IRAM BRAM port
    logic                  iram_en;
    logic [DATA_W/8-1:0]   iram_we;
    logic [RAM_AW-1:0]     iram_addr;
    logic [DATA_W-1:0]     iram_din;
    // WRAM BRAM port
    logic                  wram_en;
    logic [DATA_W/8-1:0]   wram_we;
    logic [RAM_AW-1:0]     wram_addr;
    logic [DATA_W-1:0]     wram_din;
    // Input FIFO port
    logic                  fifo_push;
    logic [DATA_W-1:0]     fifo_din;
    logic                  fifo_full;
    // Completion / status
    logic                  iram_wr_done;
    logic                  wram_wr_done;
    logic                  fifo_wr_done;
    logic                  fifo_err;
    logic [15:0]           beat_cnt;

    modport slave (
        input  axi_wr_vld, axi_wr_addr, axi_wr_data, axi_wr_strb, axi_wr_region,
        input  fifo_full,
        output iram_en, iram_we, iram_addr, iram_din,
        output wram_en, wram_we, wram_addr, wram_din,
        output fifo_push, fifo_din,
        output iram_wr_done, wram_wr_done, fifo_wr_done, fifo_err, beat_cnt
    );

    modport master (
        output axi_wr_vld, axi_wr_addr, axi_wr_data, axi_wr_strb, axi_wr_region,
        output fifo_full,
        input  iram_en, iram_we, iram_addr, iram_din,
        input  wram_en, wram_we, wram_addr, wram_din,
        input  fifo_push, fifo_din,
        input  iram_wr_done, wram_wr_done, fifo_wr_done, fifo_err, beat_cnt
    );

endinterface
`default_nettype wire

// File: rtl/wr_disp_bram_if.sv
`default_nettype none
// ============================================================================
// Module      : wr_disp_bram_if
// Description : Registered driver for one BRAM write port. When i_load is
//               high the write is placed on the port for exactly the next
//               cycle; otherwise the port is held at all-zero.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_load             - present a write next cycle
//               i_we/i_addr/i_din  - byte enables, word address, data
//               o_en/o_we/o_addr/o_din - registered BRAM port
// Revision    : 1.0 - initial release
// ============================================================================
module wr_disp_bram_if #(
    parameter int DATA_W = 32,
    parameter int RAM_AW = 9
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_load,
    input  wire logic [DATA_W/8-1:0]   i_we,
    input  wire logic [RAM_AW-1:0]     i_addr,
    input  wire logic [DATA_W-1:0]     i_din,
    output logic                       o_en,
    output logic      [DATA_W/8-1:0]   o_we,
    output logic      [RAM_AW-1:0]     o_addr,
    output logic      [DATA_W-1:0]     o_din
);

    always_ff @(posedge clk) begin
        if (rst || !i_load) begin
            o_en   <= 1'b0;
            o_we   <= '0;
            o_addr <= '0;
            o_din  <= '0;
        end else begin
            // en stays high even with a zero strobe so the beat still retires
            o_en   <= 1'b1;
            o_we   <= i_we;
            o_addr <= i_addr;
            o_din  <= i_din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wr_ram_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : wr_ram_dispatch
// Description : Takes one upstream write beat at a time, decodes its region
//               and issues a single write to the IRAM port, the WRAM port or
//               the input FIFO, then returns a one-cycle done or error pulse.
//               Waiting on a full FIFO is bounded by FIFO_TO cycles.
// Ports       : clk, rst - clock, synchronous active-high reset
//               bus      - wr_ram_dispatch_if.slave (beat in, BRAM/FIFO out,
//                          done/error pulses, beat_cnt)
// Revision    : 1.0 - initial release
// ============================================================================
module wr_ram_dispatch
    import wr_disp_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 11,
    parameter int RAM_AW  = 9,
    parameter int FIFO_TO = FIFO_TO_DEF
) (
    input  wire logic         clk,
    input  wire logic         rst,
    wr_ram_dispatch_if.slave  bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(FIFO_TO + 1);

    disp_state_t            r_state;
    disp_state_t            w_next;

    // Captured beat
    logic [RAM_AW-1:0]      r_waddr;
    logic [DATA_W-1:0]      r_data;
    logic [STRB_W-1:0]      r_strb;
    logic [1:0]             r_region;
    logic                   r_err;
    logic [CNT_W-1:0]       r_wait_cnt;

    // Registered outputs not owned by the BRAM drivers
    logic                   r_fifo_push;
    logic [DATA_W-1:0]      r_fifo_din;
    logic                   r_iram_done;
    logic                   r_wram_done;
    logic                   r_fifo_done;
    logic                   r_fifo_err;
    logic [15:0]            r_beat_cnt;

    logic w_capture, w_set_err, w_wait_inc;
    logic w_iram_ld, w_wram_ld, w_push;
    logic w_iram_done, w_wram_done, w_fifo_done, w_err_pulse;

    // Byte-lane bits of the address carry no information for word ports
    logic w_unused;
    assign w_unused = &{1'b0, bus.axi_wr_addr[1:0]};

    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_set_err   = 1'b0;
        w_wait_inc  = 1'b0;
        w_iram_ld   = 1'b0;
        w_wram_ld   = 1'b0;
        w_push      = 1'b0;
        w_iram_done = 1'b0;
        w_wram_done = 1'b0;
        w_fifo_done = 1'b0;
        w_err_pulse = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.axi_wr_vld) begin
                    w_capture = 1'b1;
                    case (bus.axi_wr_region)
                        REG_IRAM, REG_WRAM: w_next = S_RAM_WR;
                        REG_FIFO:           w_next = S_FIFO_WAIT;
                        default: begin
                            w_next    = S_RESP;
                            w_set_err = 1'b1;
                        end
                    endcase
                end
            end
            S_RAM_WR: begin
                w_iram_ld = (r_region == REG_IRAM);
                w_wram_ld = (r_region == REG_WRAM);
                w_next    = S_RESP;
            end
            S_FIFO_WAIT: begin
                // A free slot wins over an expiring timeout in the same cycle
                if (!bus.fifo_full) begin
                    w_push = 1'b1;
                    w_next = S_RESP;
                end else if (r_wait_cnt == CNT_W'(FIFO_TO - 1)) begin
                    w_set_err = 1'b1;
                    w_next    = S_RESP;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            S_RESP: begin
                w_err_pulse = r_err;
                w_iram_done = !r_err && (r_region == REG_IRAM);
                w_wram_done = !r_err && (r_region == REG_WRAM);
                w_fifo_done = !r_err && (r_region == REG_FIFO);
                w_next      = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_waddr    <= '0;
            r_data     <= '0;
            r_strb     <= '0;
            r_region   <= '0;
            r_err      <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (w_capture) begin
                r_waddr  <= bus.axi_wr_addr[ADDR_W-1:2];
                r_data   <= bus.axi_wr_data;
                r_strb   <= bus.axi_wr_strb;
                r_region <= bus.axi_wr_region;
            end
            if (w_capture)      r_err <= w_set_err;
            else if (w_set_err) r_err <= 1'b1;
            if (w_capture)       r_wait_cnt <= '0;
            else if (w_wait_inc) r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fifo_push <= 1'b0;
            r_fifo_din  <= '0;
            r_iram_done <= 1'b0;
            r_wram_done <= 1'b0;
            r_fifo_done <= 1'b0;
            r_fifo_err  <= 1'b0;
            r_beat_cnt  <= '0;
        end else begin
            r_fifo_push <= w_push;
            r_fifo_din  <= w_push ? r_data : '0;
            r_iram_done <= w_iram_done;
            r_wram_done <= w_wram_done;
            r_fifo_done <= w_fifo_done;
            r_fifo_err  <= w_err_pulse;
            if ((w_iram_done || w_wram_done || w_fifo_done) && (r_beat_cnt != 16'hFFFF))
                r_beat_cnt <= r_beat_cnt + 16'd1;
        end
    end

    wr_disp_bram_if #(.DATA_W(DATA_W), .RAM_AW(RAM_AW)) u_iram (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_iram_ld),
        .i_we   (r_strb),
        .i_addr (r_waddr),
        .i_din  (r_data),
        .o_en   (bus.iram_en),
        .o_we   (bus.iram_we),
        .o_addr (bus.iram_addr),
        .o_din  (bus.iram_din)
    );

    wr_disp_bram_if #(.DATA_W(DATA_W), .RAM_AW(RAM_AW)) u_wram (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_wram_ld),
        .i_we   (r_strb),
        .i_addr (r_waddr),
        .i_din  (r_data),
        .o_en   (bus.wram_en),
        .o_we   (bus.wram_we),
        .o_addr (bus.wram_addr),
        .o_din  (bus.wram_din)
    );

    assign bus.fifo_push    = r_fifo_push;
    assign bus.fifo_din     = r_fifo_din;
    assign bus.iram_wr_done = r_iram_done;
    assign bus.wram_wr_done = r_wram_done;
    assign bus.fifo_wr_done = r_fifo_done;
    assign bus.fifo_err     = r_fifo_err;
    assign bus.beat_cnt     = r_beat_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wr_ram_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_wr_ram_dispatch
// Description : Self-checking bench for wr_ram_dispatch. Each beat's expected
//               output timeline (port activity offset, done/error offset,
//               beat count) is derived from the beat's region and FIFO
//               backpressure length; BRAM contents and FIFO stream are
//               compared against an expected memory image and queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_ram_dispatch;
    import wr_disp_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wr_ram_dispatch_if #(.DATA_W(32), .ADDR_W(11), .RAM_AW(9)) bus ();

    wr_ram_dispatch #(.DATA_W(32), .ADDR_W(11), .RAM_AW(9), .FIFO_TO(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [15:0] exp_cnt;
    logic [31:0] iram_m [512];
    logic [31:0] wram_m [512];
    logic [31:0] iram_e [512];
    logic [31:0] wram_e [512];
    logic [31:0] act_q [$];
    logic [31:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM and FIFO behaviour seen from the ports
    always @(posedge clk) begin
        if (bus.iram_en)
            for (int b = 0; b < 4; b++)
                if (bus.iram_we[b]) iram_m[bus.iram_addr][8*b +: 8] <= bus.iram_din[8*b +: 8];
        if (bus.wram_en)
            for (int b = 0; b < 4; b++)
                if (bus.wram_we[b]) wram_m[bus.wram_addr][8*b +: 8] <= bus.wram_din[8*b +: 8];
        if (bus.fifo_push) act_q.push_back(bus.fifo_din);
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic check_outputs(input logic [45:0] e_i, input logic [45:0] e_w,
                                 input logic [32:0] e_f, input logic [3:0] e_p,
                                 input logic [15:0] e_c);
        check_val("iram_port", {bus.iram_en, bus.iram_we, bus.iram_addr, bus.iram_din}, e_i);
        check_val("wram_port", {bus.wram_en, bus.wram_we, bus.wram_addr, bus.wram_din}, e_w);
        check_val("fifo_port", {bus.fifo_push, bus.fifo_din}, e_f);
        check_val("pulses", {bus.iram_wr_done, bus.wram_wr_done, bus.fifo_wr_done, bus.fifo_err}, e_p);
        check_val("beat_cnt", bus.beat_cnt, e_c);
    endtask

    task automatic idle_cycles(input int n);
        bus.axi_wr_vld = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); @(negedge clk);
            check_outputs('0, '0, '0, '0, exp_cnt);
            bus.fifo_full = 1'($urandom % 2);
        end
    endtask

    // Called at a negedge while the dispatcher is idle; returns at the
    // negedge of the done/error cycle with vld still high.
    // f = cycles fifo_full stays high in the wait phase (>= TO means stuck).
    task automatic run_beat(input logic [1:0] rg, input logic [10:0] ad, input logic [31:0] dt,
                            input logic [3:0] sb, input int f, output int done_cyc);
        int          t_act, t_end;
        bit          ok;
        logic [45:0] ram_v, e_i, e_w;
        logic [32:0] e_f;
        logic [3:0]  e_p;
        logic [15:0] e_c;
        bus.axi_wr_vld    = 1'b1;
        bus.axi_wr_region = rg;
        bus.axi_wr_addr   = ad;
        bus.axi_wr_data   = dt;
        bus.axi_wr_strb   = sb;
        ram_v = {1'b1, sb, ad[10:2], dt};
        if (rg == REG_IRAM || rg == REG_WRAM) begin
            t_act = 1; t_end = 2; ok = 1'b1;
        end else if (rg == REG_RSVD) begin
            t_act = -1; t_end = 1; ok = 1'b0;
        end else if (f < TO) begin
            t_act = f + 1; t_end = f + 2; ok = 1'b1;
        end else begin
            t_act = -1; t_end = TO + 1; ok = 1'b0;
        end
        for (int k = 0; k <= t_end; k++) begin
            @(posedge clk); @(negedge clk);
            e_i = '0; e_w = '0; e_f = '0; e_p = '0; e_c = exp_cnt;
            if (k == t_act) begin
                if (rg == REG_IRAM)      e_i = ram_v;
                else if (rg == REG_WRAM) e_w = ram_v;
                else                     e_f = {1'b1, dt};
            end
            if (k == t_end) begin
                if (!ok)                 e_p = 4'b0001;
                else if (rg == REG_IRAM) e_p = 4'b1000;
                else if (rg == REG_WRAM) e_p = 4'b0100;
                else                     e_p = 4'b0010;
                if (ok && exp_cnt != 16'hFFFF) e_c = exp_cnt + 16'd1;
            end
            check_outputs(e_i, e_w, e_f, e_p, e_c);
            if (rg == REG_FIFO) bus.fifo_full = (k < f);
            else                bus.fifo_full = 1'($urandom % 2);
        end
        done_cyc = cyc;
        if (ok) begin
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            if (rg == REG_IRAM)      iram_e[ad[10:2]] = merge(iram_e[ad[10:2]], dt, sb);
            else if (rg == REG_WRAM) wram_e[ad[10:2]] = merge(wram_e[ad[10:2]], dt, sb);
            else                     exp_q.push_back(dt);
        end
    endtask

    initial begin
        int          dc, base, nq;
        logic [15:0] cnt_before;
        for (int i = 0; i < 512; i++) begin
            iram_m[i] = '0; wram_m[i] = '0; iram_e[i] = '0; wram_e[i] = '0;
        end
        exp_cnt = '0;
        rst = 1'b1;
        bus.axi_wr_vld = 1'b0; bus.axi_wr_addr = '0; bus.axi_wr_data = '0;
        bus.axi_wr_strb = '0;  bus.axi_wr_region = '0; bus.fifo_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs('0, '0, '0, '0, 16'd0);
        rst = 1'b0;

        // IRAM full word
        run_beat(REG_IRAM, 11'h010, 32'h0000000A, 4'hF, 0, dc);
        check_val("iram_word4", iram_m[4], 32'h0000000A);
        idle_cycles(1);

        // WRAM partial strobe at the top word
        run_beat(REG_WRAM, 11'h7FC, 32'hAABBCCDD, 4'h5, 0, dc);
        check_val("wram_word511", wram_m[511], 32'h00BB00DD);
        idle_cycles(2);

        // Back-to-back IRAM beats with vld held high throughout
        base = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            run_beat(REG_IRAM, 11'(4 * i), 32'h1000 + i, 4'hF, 0, dc);
            check_val("b2b_done_cycle", dc - base, 3 * i + 2);
        end
        check_val("b2b_beat_cnt", bus.beat_cnt, 16'd6);
        idle_cycles(1);

        // FIFO backpressure, 5 full cycles
        run_beat(REG_FIFO, 11'h000, 32'hCAFE0005, 4'hF, 5, dc);
        idle_cycles(1);

        // Push coincides with the timeout boundary
        run_beat(REG_FIFO, 11'h000, 32'hCAFE000F, 4'hF, TO - 1, dc);
        idle_cycles(1);

        // Timeout then reserved region
        cnt_before = exp_cnt;
        run_beat(REG_FIFO, 11'h000, 32'hDEAD0001, 4'hF, 1000, dc);
        run_beat(REG_RSVD, 11'h020, 32'hDEAD0003, 4'hF, 0, dc);
        check_val("err_cnt_unchanged", bus.beat_cnt, cnt_before);
        idle_cycles(1);

        // Zero strobe still completes
        run_beat(REG_WRAM, 11'h100, 32'h12345678, 4'h0, 0, dc);
        idle_cycles(1);

        // Reset while waiting on a full FIFO
        bus.axi_wr_vld = 1'b1; bus.axi_wr_region = REG_FIFO;
        bus.axi_wr_data = 32'hBAD0BAD0; bus.fifo_full = 1'b1;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            check_outputs('0, '0, '0, '0, exp_cnt);
        end
        rst = 1'b1; bus.axi_wr_vld = 1'b0; bus.fifo_full = 1'b0;
        @(posedge clk); @(negedge clk);
        exp_cnt = '0;
        check_outputs('0, '0, '0, '0, exp_cnt);
        rst = 1'b0;
        idle_cycles(20);
        run_beat(REG_IRAM, 11'h040, 32'h5A5A5A5A, 4'hF, 0, dc);
        idle_cycles(1);

        // Randomized beats with random gaps
        for (int n = 0; n < 60; n++) begin
            run_beat(2'($urandom % 4), 11'($urandom), $urandom, 4'($urandom),
                     int'($urandom % 22), dc);
            idle_cycles(int'($urandom % 3));
        end
        idle_cycles(2);

        for (int i = 0; i < 512; i++) begin
            check_val("iram_mem", iram_m[i], iram_e[i]);
            check_val("wram_mem", wram_m[i], wram_e[i]);
        end
        check_val("fifo_depth", act_q.size(), exp_q.size());
        nq = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < nq; i++) check_val("fifo_data", act_q[i], exp_q[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
